// File: rtl/decode_stage_pipe.sv
// RV32I-subset decode stage: register file with WB bypass, decode/control, immediates,
// hazard stalls, branch resolution and a registered ID/EX stage. Optional: DECODE_UNSIGNED_BR_EN.
module decode_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int REG_AW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruccion,
   input  logic [XLEN-1:0] PC,
   input  logic            reg_write_signal,
   input  logic [4:0]      write_reg,
   input  logic [XLEN-1:0] write_data,
   output logic            Select_PC,
   output logic [XLEN-1:0] dir_salto,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] Rs1,
   output logic [XLEN-1:0] Rs2,
   output logic [XLEN-1:0] inmediato,
   output logic [4:0]      rd_E,
   output logic            RegWriteE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic [1:0]      MEM_CtrlE,
   output logic            illegal
);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
      ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_LW = 2'b01, MEM_SW = 2'b10} mem_op_e;
   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S} imm_sel_e;

   logic [6:0] opcode, funct7;
   logic [4:0] rd_f, rs1_f, rs2_f;
   logic [2:0] funct3;

   assign opcode = instruccion[6:0];
   assign rd_f   = instruccion[11:7];
   assign funct3 = instruccion[14:12];
   assign rs1_f  = instruccion[19:15];
   assign rs2_f  = instruccion[24:20];
   assign funct7 = instruccion[31:25];

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_val;
   assign imm_i = {{(XLEN-12){instruccion[31]}}, instruccion[31:20]};
   assign imm_s = {{(XLEN-12){instruccion[31]}}, instruccion[31:25], instruccion[11:7]};
   assign imm_b = {{(XLEN-13){instruccion[31]}}, instruccion[31], instruccion[7],
                   instruccion[30:25], instruccion[11:8], 1'b0};

   // Register file: x0 is never written, so its entry stays at its reset value of 0.
   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en, byp1, byp2;
   logic [XLEN-1:0] rd1, rd2;

   assign wr_en = reg_write_signal && (write_reg != 5'd0) && ((write_reg >> REG_AW) == 5'd0);
   assign byp1  = reg_write_signal && (write_reg != 5'd0) && (write_reg == rs1_f);
   assign byp2  = reg_write_signal && (write_reg != 5'd0) && (write_reg == rs2_f);
   assign rd1   = byp1 ? write_data : regs[rs1_f[REG_AW-1:0]];
   assign rd2   = byp2 ? write_data : regs[rs2_f[REG_AW-1:0]];

   // NOTE: arrays are usually left unreset; here every architectural register must clear to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[write_reg[REG_AW-1:0]] <= write_data;
      end
   end

   // Instruction decode
   logic     dec_legal, dec_fwd, dec_branch, use_rs1, use_rs2, use_rd, alu_src, reg_wr;
   alu_op_e  alu_ctl;
   mem_op_e  mem_ctl;
   imm_sel_e imm_sel;
   logic     shamt_ok;

   assign shamt_ok = (instruccion[31:26] == 6'd0) && ((XLEN == 64) || !instruccion[25]);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      dec_legal  = 1'b0;
      dec_fwd    = 1'b0;
      dec_branch = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      use_rd     = 1'b0;
      alu_src    = 1'b0;
      reg_wr     = 1'b0;
      alu_ctl    = ALU_ADD;
      mem_ctl    = MEM_NONE;
      imm_sel    = IMM_NONE;
      case (opcode)
         OP_REG: begin
            {use_rs1, use_rs2, use_rd, reg_wr, dec_fwd, dec_legal} = 6'b111111;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  alu_ctl = ALU_ADD;
                  3'b001:  alu_ctl = ALU_SLL;
                  3'b010:  alu_ctl = ALU_SLT;
                  3'b100:  alu_ctl = ALU_XOR;
                  3'b101:  alu_ctl = ALU_SRL;
                  3'b110:  alu_ctl = ALU_OR;
                  3'b111:  alu_ctl = ALU_AND;
                  default: dec_legal = 1'b0;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               alu_ctl = ALU_SUB;
            end else begin
               dec_legal = 1'b0;
            end
         end
         OP_IMM: begin
            {use_rs1, use_rd, reg_wr, alu_src, dec_fwd, dec_legal} = 6'b111111;
            imm_sel = IMM_I;
            case (funct3)
               3'b000: alu_ctl = ALU_ADD;
               3'b010: alu_ctl = ALU_SLT;
               3'b100: alu_ctl = ALU_XOR;
               3'b110: alu_ctl = ALU_OR;
               3'b111: alu_ctl = ALU_AND;
               3'b001: begin alu_ctl = ALU_SLL; dec_legal = shamt_ok; end
               3'b101: begin alu_ctl = ALU_SRL; dec_legal = shamt_ok; end
               default: dec_legal = 1'b0;
            endcase
         end
         OP_LOAD: begin
            {use_rs1, use_rd, reg_wr, alu_src, dec_fwd} = 5'b11111;
            dec_legal = (funct3 == 3'b010);
            mem_ctl   = MEM_LW;
            imm_sel   = IMM_I;
         end
         OP_STORE: begin
            {use_rs1, use_rs2, alu_src, dec_fwd} = 4'b1111;
            dec_legal = (funct3 == 3'b010);
            mem_ctl   = MEM_SW;
            imm_sel   = IMM_S;
         end
         OP_BRANCH: begin
            {use_rs1, use_rs2, dec_branch} = 3'b111;
            case (funct3)
               3'b000, 3'b001, 3'b100, 3'b101: dec_legal = 1'b1;
`ifdef DECODE_UNSIGNED_BR_EN
               3'b110, 3'b111:                 dec_legal = 1'b1;
`endif
               default:                        dec_legal = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      case (imm_sel)
         IMM_I:   imm_val = imm_i;
         IMM_S:   imm_val = imm_s;
         default: imm_val = '0;
      endcase
   end

   // A register field wider than the implemented file makes the instruction illegal.
   logic addr_ok, op_ok, fwd_op, br_op, src1, src2;
   assign addr_ok = !(use_rs1 && ((rs1_f >> REG_AW) != 5'd0)) &&
                    !(use_rs2 && ((rs2_f >> REG_AW) != 5'd0)) &&
                    !(use_rd  && ((rd_f  >> REG_AW) != 5'd0));
   assign op_ok   = dec_legal && addr_ok;
   assign fwd_op  = op_ok && dec_fwd;
   assign br_op   = op_ok && dec_branch;
   assign src1    = op_ok && use_rs1;
   assign src2    = op_ok && use_rs2;

   logic br_true;
   always_comb begin
      br_true = 1'b0;
      case (funct3)
         3'b000:  br_true = (rd1 == rd2);
         3'b001:  br_true = (rd1 != rd2);
         3'b100:  br_true = ($signed(rd1) <  $signed(rd2));
         3'b101:  br_true = ($signed(rd1) >= $signed(rd2));
         3'b110:  br_true = (rd1 <  rd2);
         3'b111:  br_true = (rd1 >= rd2);
         default: br_true = 1'b0;
      endcase
   end

   // Hazards and handshake
   logic load_use, br_dep, stall, accept;
   assign load_use = out_valid && (MEM_CtrlE == MEM_LW) && (rd_E != 5'd0) &&
                     ((src1 && (rd_E == rs1_f)) || (src2 && (rd_E == rs2_f)));
   assign br_dep   = br_op && out_valid && RegWriteE && (rd_E != 5'd0) &&
                     ((rd_E == rs1_f) || (rd_E == rs2_f));
   assign stall    = in_valid && (load_use || br_dep);
   assign in_ready = reset && !stall && (out_ready || !out_valid);
   assign accept   = in_valid && in_ready;

   assign Select_PC = accept && br_op && br_true;
   assign dir_salto = PC + imm_b;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         illegal     <= 1'b0;
         Rs1         <= '0;
         Rs2         <= '0;
         inmediato   <= '0;
         rd_E        <= '0;
         RegWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= '0;
         MEM_CtrlE   <= '0;
      end else begin
         illegal <= accept && !op_ok;
         if (accept && fwd_op) begin
            out_valid   <= 1'b1;
            Rs1         <= rd1;
            Rs2         <= rd2;
            inmediato   <= imm_val;
            rd_E        <= use_rd ? rd_f : 5'd0;
            RegWriteE   <= reg_wr;
            ALUSrcE     <= alu_src;
            ALUControlE <= alu_ctl;
            MEM_CtrlE   <= mem_ctl;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe (default XLEN=32, NREGS=32).
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] instruccion, PC;
   logic        reg_write_signal;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        Select_PC;
   logic [31:0] dir_salto;
   logic        out_valid, out_ready;
   logic [31:0] Rs1, Rs2, inmediato;
   logic [4:0]  rd_E;
   logic        RegWriteE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [1:0]  MEM_CtrlE;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   decode_stage_pipe dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instruccion(instruccion), .PC(PC), .reg_write_signal(reg_write_signal),
      .write_reg(write_reg), .write_data(write_data), .Select_PC(Select_PC),
      .dir_salto(dir_salto), .out_valid(out_valid), .out_ready(out_ready),
      .Rs1(Rs1), .Rs2(Rs2), .inmediato(inmediato), .rd_E(rd_E), .RegWriteE(RegWriteE),
      .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MEM_CtrlE(MEM_CtrlE), .illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;

`ifdef DECODE_UNSIGNED_BR_EN
   localparam logic [31:0] EXP_BLTU_SEL = 32'd1;
   localparam logic [31:0] EXP_BLTU_ILL = 32'd0;
`else
   localparam logic [31:0] EXP_BLTU_SEL = 32'd0;
   localparam logic [31:0] EXP_BLTU_ILL = 32'd1;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      reg_write_signal = 1'b1;
      write_reg        = r;
      write_data       = d;
      step();
      reg_write_signal = 1'b0;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   initial begin
      reset = 1'b0; in_valid = 1'b0; instruccion = '0; PC = '0;
      reg_write_signal = 1'b0; write_reg = '0; write_data = '0; out_ready = 1'b1;
      step(); step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_sel_pc",    32'(Select_PC), 32'd0);
      check("rst_illegal",   32'(illegal),   32'd0);
      check("rst_rs1",       Rs1,            32'd0);
      check("rst_rd_e",      32'(rd_E),      32'd0);
      reset = 1'b1;
      #1 check("rdy_after_rst", 32'(in_ready), 32'd1);

      // addi x6,x5,3 after WB x5=7
      wb_write(5'd5, 32'h7);
      instruccion = enc_i(12'd3, 5'd5, 3'b000, 5'd6, OP_IMM); in_valid = 1'b1;
      #1 check("addi_in_ready", 32'(in_ready), 32'd1);
      step(); in_valid = 1'b0;
      check("addi_valid",  32'(out_valid),   32'd1);
      check("addi_rs1",    Rs1,              32'd7);
      check("addi_imm",    inmediato,        32'd3);
      check("addi_aluctl", 32'(ALUControlE), 32'd0);
      check("addi_alusrc", 32'(ALUSrcE),     32'd1);
      check("addi_rd",     32'(rd_E),        32'd6);
      check("addi_regwr",  32'(RegWriteE),   32'd1);

      // add x2,x1,x0 while WB writes x1=0xA5 in the same cycle
      reg_write_signal = 1'b1; write_reg = 5'd1; write_data = 32'hA5;
      instruccion = enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd2); in_valid = 1'b1;
      step(); reg_write_signal = 1'b0; in_valid = 1'b0;
      check("byp_rs1",    Rs1,          32'hA5);
      check("byp_rs2",    Rs2,          32'd0);
      check("byp_alusrc", 32'(ALUSrcE), 32'd0);
      check("byp_rd",     32'(rd_E),    32'd2);

      // WB to x0 is discarded
      wb_write(5'd0, 32'hFF);
      instruccion = enc_r(7'd0, 5'd5, 5'd0, 3'b000, 5'd7); in_valid = 1'b1;
      step(); in_valid = 1'b0;
      check("x0_rs1", Rs1, 32'd0);
      check("x0_rs2", Rs2, 32'd7);

      // lw x3,0(x4) then add x5,x3,x3 -> one stall and a bubble
      instruccion = enc_i(12'd0, 5'd4, 3'b010, 5'd3, OP_LOAD); in_valid = 1'b1;
      step();
      check("lw_valid", 32'(out_valid), 32'd1);
      check("lw_mem",   32'(MEM_CtrlE), 32'd1);
      check("lw_rd",    32'(rd_E),      32'd3);
      instruccion = enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd5);
      #1 check("lu_stall", 32'(in_ready), 32'd0);
      step();
      check("lu_bubble",  32'(out_valid), 32'd0);
      check("lu_release", 32'(in_ready),  32'd1);
      step(); in_valid = 1'b0;
      check("lu_add_valid", 32'(out_valid), 32'd1);
      check("lu_add_rd",    32'(rd_E),      32'd5);
      check("lu_add_mem",   32'(MEM_CtrlE), 32'd0);

      // beq / bne with x1=x2=9 at PC 0x40, offset -8
      wb_write(5'd1, 32'd9);
      wb_write(5'd2, 32'd9);
      PC = 32'h40; instruccion = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000); in_valid = 1'b1;
      #1 check("beq_sel",   32'(Select_PC), 32'd1);
      check("beq_target",   dir_salto,      32'h38);
      step();
      check("beq_no_op",    32'(out_valid), 32'd0);
      instruccion = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001);
      #1 check("bne_sel",   32'(Select_PC), 32'd0);
      step(); in_valid = 1'b0;

      // Branch operand produced by the op in ID/EX -> stall one cycle
      instruccion = enc_i(12'd1, 5'd0, 3'b000, 5'd8, OP_IMM); in_valid = 1'b1;
      step();
      PC = 32'h80; instruccion = enc_b(13'd8, 5'd0, 5'd8, 3'b000);
      #1 check("brdep_stall", 32'(in_ready),  32'd0);
      check("brdep_nosel",    32'(Select_PC), 32'd0);
      step();
      check("brdep_bubble",   32'(out_valid), 32'd0);
      check("brdep_sel",      32'(Select_PC), 32'd1);
      check("brdep_target",   dir_salto,      32'h88);
      step(); in_valid = 1'b0;

      // sw x2,4(x1) held for 3 cycles by out_ready=0
      instruccion = enc_s(12'd4, 5'd2, 5'd1); in_valid = 1'b1;
      step();
      out_ready = 1'b0; instruccion = enc_i(12'd5, 5'd0, 3'b000, 5'd9, OP_IMM);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("sw_hold_valid", 32'(out_valid), 32'd1);
         check("sw_hold_mem",   32'(MEM_CtrlE), 32'd2);
         check("sw_hold_imm",   inmediato,      32'd4);
         check("sw_hold_rs2",   Rs2,            32'd9);
         check("sw_hold_ready", 32'(in_ready),  32'd0);
         step();
      end
      out_ready = 1'b1;
      #1 check("sw_release_ready", 32'(in_ready), 32'd1);
      step(); in_valid = 1'b0;
      check("next_valid", 32'(out_valid), 32'd1);
      check("next_rd",    32'(rd_E),      32'd9);
      check("next_imm",   inmediato,      32'd5);
      check("next_mem",   32'(MEM_CtrlE), 32'd0);

      // Illegal: LUI opcode, then sra
      instruccion = 32'h0000_10B7; in_valid = 1'b1;
      step(); in_valid = 1'b0;
      check("lui_illegal", 32'(illegal),   32'd1);
      check("lui_no_op",   32'(out_valid), 32'd0);
      step();
      check("lui_pulse_end", 32'(illegal), 32'd0);
      instruccion = enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3); in_valid = 1'b1;
      step(); in_valid = 1'b0;
      check("sra_illegal", 32'(illegal),   32'd1);
      check("sra_no_op",   32'(out_valid), 32'd0);

      // Unsigned vs signed compares: x1=1, x2=0xFFFF_FFFF, offset +16 at 0x100
      wb_write(5'd1, 32'd1);
      wb_write(5'd2, 32'hFFFF_FFFF);
      PC = 32'h100; instruccion = enc_b(13'd16, 5'd2, 5'd1, 3'b110); in_valid = 1'b1;
      #1 check("bltu_sel", 32'(Select_PC), EXP_BLTU_SEL);
      step(); in_valid = 1'b0;
      check("bltu_illegal", 32'(illegal), EXP_BLTU_ILL);
      instruccion = enc_b(13'd16, 5'd2, 5'd1, 3'b100); in_valid = 1'b1;
      #1 check("blt_sel", 32'(Select_PC), 32'd0);
      step();
      instruccion = enc_b(13'd16, 5'd2, 5'd1, 3'b101);
      #1 check("bge_sel",  32'(Select_PC), 32'd1);
      check("bge_target",  dir_salto,      32'h110);
      step(); in_valid = 1'b0;

      // Branch compare sees the same-cycle WB value (x2 <- 1, x1 = 1)
      reg_write_signal = 1'b1; write_reg = 5'd2; write_data = 32'd1;
      instruccion = enc_b(13'd16, 5'd2, 5'd1, 3'b000); in_valid = 1'b1;
      #1 check("beq_byp_sel", 32'(Select_PC), 32'd1);
      step(); reg_write_signal = 1'b0; in_valid = 1'b0;

      // Reset asserted during a load-use stall
      instruccion = enc_i(12'd0, 5'd0, 3'b010, 5'd3, OP_LOAD); in_valid = 1'b1;
      step();
      instruccion = enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd5);
      #1 check("rst_stall_pre", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_ready", 32'(in_ready),  32'd0);
      check("rst_mid_sel",   32'(Select_PC), 32'd0);
      step(); in_valid = 1'b0; reset = 1'b1;
      instruccion = enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd10); in_valid = 1'b1;
      step(); in_valid = 1'b0;
      check("rst_rf_cleared", Rs1,            32'd0);
      check("rst_after_op",   32'(out_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised pipelined decode stage for the RV32I-subset core.
- Contains the register file, instruction decode and control generation, and the I/S/B immediate generator.
- Adds WB-to-ID bypass, load-use and branch-operand hazard stalls, branch resolution with fetch flush, and a registered ID/EX output with a valid/ready handshake.
- Sits between fetch (upstream handshake) and execute (downstream handshake).

Parameters:
- XLEN, 32, datapath, register and PC width; legal values 32 or 64. Immediates are sign-extended to XLEN.
- NREGS, 32, number of architectural registers; power of two, 2..32. Register x0 reads as 0.
- REG_AW, $clog2(NREGS), register address width. Instruction address bits above REG_AW-1 must be 0, otherwise the instruction is illegal.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents instruccion/PC
- in_ready  out  1  decode accepts the instruction this cycle
- instruccion  in  32  instruction word
- PC  in  XLEN  address of instruccion
- reg_write_signal  in  1  WB register write enable
- write_reg  in  5  WB destination register
- write_data  in  XLEN  WB data
- Select_PC  out  1  branch taken; fetch loads dir_salto and discards its in-flight word
- dir_salto  out  XLEN  PC + B-immediate
- out_valid  out  1  ID/EX register holds a valid op
- out_ready  in  1  execute accepts the op
- Rs1, Rs2  out  XLEN  operand values (registered)
- inmediato  out  XLEN  selected immediate (registered)
- rd_E  out  5  destination register (registered)
- RegWriteE, ALUSrcE  out  1  control (registered)
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- MEM_CtrlE  out  2  00 none, 01 load word, 10 store word
- illegal  out  1  one-cycle pulse when an illegal instruction is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0; out_valid=0, illegal=0, all registered outputs 0.
  - in_ready and Select_PC are 0 while reset is held.
- Register file:
  - write on rising clk when reg_write_signal=1 and write_reg!=0.
  - reads are combinational.
  - bypass: if read address == write_reg, address != 0, and reg_write_signal=1, the read returns write_data in the same cycle.
- Decode:
  - R-type 0110011: add/sub/sll/slt/xor/srl/or/and.
  - I-ALU 0010011: addi/slti/xori/ori/andi/slli/srli.
  - Load 0000011: funct3 010 only; add, ALUSrc=1, I-imm, MEM 01, RegWrite=1.
  - Store 0100011: funct3 010 only; add, ALUSrc=1, S-imm, MEM 10, RegWrite=0.
  - Branch 1100011: beq 000, bne 001, blt 100, bge 101 (signed).
  - Anything else, including sltu and sra, is illegal.
  - B-imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- Hazards (decoded combinationally from instruccion):
  - load_use: out_valid=1, MEM_CtrlE=01, rd_E!=0, and rd_E equals a source the current instruction uses.
  - br_dep: current instruction is a branch, out_valid=1, RegWriteE=1, rd_E!=0, and rd_E equals rs1 or rs2.
  - stall = in_valid & (load_use | br_dep).
- Handshake:
  - in_ready = reset & ~stall & (out_ready | ~out_valid).
  - accept = in_valid & in_ready.
  - On accept of an ALU/load/store op: the ID/EX register loads and out_valid=1 next cycle.
  - On accept of a branch or illegal instruction: nothing is forwarded; out_valid clears if out_ready=1.
  - No accept and out_ready=1: out_valid clears (bubble).
  - out_valid=1 and out_ready=0: all ID/EX outputs hold.
- Branch:
  - Select_PC = accept & branch & condition true, evaluated on bypassed Rs1/Rs2.
  - Combinational, one cycle.
  - Untaken branch has no effect beyond consumption.
- illegal: registered, high for exactly one cycle per accepted illegal instruction.
- Simultaneous WB write and read of the same register: the bypass value wins, both for operands and for the branch compare.
- Reset asserted mid-stall: the pending op is dropped; no write occurs.

Optional Feature:
- DECODE_UNSIGNED_BR_EN
- Defined: funct3 110 (bltu) and 111 (bgeu) are legal branches using unsigned comparison.
- Undefined: funct3 110 and 111 are illegal (illegal pulse, no Select_PC).

Test Plan:
- Reset then WB write x5=0x0000_0007; addi x6,x5,3 with out_ready=1 -> next cycle out_valid=1, Rs1=7, inmediato=3, ALUControlE=000, ALUSrcE=1, rd_E=6.
- Same-cycle WB write x1=0xA5 and decode of add x2,x1,x0 -> Rs1=0xA5. A WB write to x0 of 0xFF -> a later read of x0 gives 0.
- lw x3,0(x4) followed by add x5,x3,x3 -> in_ready=0 for one cycle, a bubble is issued (out_valid=0), then add is accepted.
- x1=x2=9, beq x1,x2,-8 at PC=0x40 -> Select_PC=1, dir_salto=0x38, no ID/EX op. bne with the same operands -> Select_PC=0.
- out_ready=0 for 3 cycles holding a sw op -> outputs stable, in_ready=0; release -> op consumed, the next instruction is accepted.
- Opcode 0110111, and bltu with the macro off -> illegal pulses one cycle, out_valid=0. bltu with the macro on, x1=1, x2=0xFFFF_FFFF -> Select_PC=1.
